hack_pc: RTL and testbench
==========================

# hack_pc

Program counter with jump-condition decode for the Hack-style CPU datapath. Each enabled cycle it either increments, or loads the A-register target when the current C-instruction's jump bits match the ALU flags (`zr`, `ng`). It is also the first sequential stage built on the gate library. It sits between the ALU flag outputs and the instruction ROM address input, and additionally reports taken-jump statistics and a sticky halt (self-loop) flag.

## Interface
- `WIDTH`, 15, PC / address width in bits.
- `CNT_W`, 16, width of the taken-jump counter.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance enable; 0 = stall, all state holds.
- `clr`  in  1  synchronous clear (PC, counter, halt); priority over `en`.
- `is_c`  in  1  current instruction is a C-instruction; jumps only when 1.
- `jump`  in  3  jump bits j1 j2 j3 (`jump[2]`=lt, `jump[1]`=eq, `jump[0]`=gt).
- `zr`  in  1  ALU result zero flag.
- `ng`  in  1  ALU result negative flag.
- `target`  in  WIDTH  jump destination (A register low bits).
- `pc`  out  WIDTH  current instruction address.
- `taken`  out  1  registered: the last enabled cycle took a jump.
- `halted`  out  1  sticky: a taken jump targeted its own address.
- `jump_count`  out  CNT_W  saturating count of taken jumps.

## Operation
- Condition: `cond = is_c & ((jump[2]&ng) | (jump[1]&zr) | (jump[0]&~zr&~ng))`. `jump`=3'b111 is unconditional. `zr`=`ng`=1 is not filtered; the formula applies literally.
- Priority per rising edge, highest first: `clr`, `en`, hold.
- `clr`=1: `pc`←0, `taken`←0, `halted`←0, `jump_count`←0, regardless of `en`.
- `en`=1 and `cond`=1: `pc`←`target`, `taken`←1, `jump_count`←`jump_count`+1 saturating at 2^CNT_W−1. If `target`==`pc` also set `halted`←1.
- `en`=1 and `cond`=0: `pc`←`pc`+1 modulo 2^WIDTH (0x7FFF→0x0000), `taken`←0.
- `en`=0: all registers hold, including `taken`.
- `halted` is sticky and is cleared only by `clr` or reset. The PC keeps executing normally while `halted`=1; a self-jump continues to jump to itself and keeps counting.
- `target` is used as-is, with no masking beyond WIDTH bits.
- All outputs are direct register outputs, with no combinational path from inputs to outputs.

## Timing
- Async reset: `rst_n` low forces `pc`=0, `taken`=0, `halted`=0, `jump_count`=0 immediately, independent of `clk`. Release is synchronous to the next rising edge; the first update happens on the first edge with `rst_n`=1.
- Reset mid-operation overrides any in-flight load or increment. No partial update is visible.
- Latency is 1 cycle: inputs sampled at edge N are reflected on `pc`/`taken`/`halted`/`jump_count` after edge N.
- `zr`, `ng`, `jump`, `is_c`, `target` must be stable around the edge. They are sampled only when `en`=1.
- Counter saturation: at 2^CNT_W−1 a further taken jump leaves the count unchanged, and `taken` still pulses.
- Wrap plus jump in the same cycle: jump wins; no increment.

## Test plan
- Reset and increment: hold `rst_n`=0, then release with `en`=1, `is_c`=0 for 5 cycles -> `pc` goes 0,1,2,3,4,5; `taken`=0; `jump_count`=0.
- Jump decode sweep: `pc`=0x0010, `target`=0x0100, all 8 `jump` codes × (zr,ng) ∈ {(0,0),(1,0),(0,1)}, restoring `pc` via `clr` or reload before each case -> `pc`=0x0100 exactly when the formula is true, otherwise 0x0011. JEQ with zr=1 jumps; JGT with ng=1 does not; 3'b111 always jumps. `is_c`=0 with `jump`=3'b111 -> increment.
- Wrap and stall: `pc`=0x7FFE, `en`=1 for 2 cycles -> `pc` shows 0x7FFF then 0x0000. Then `en`=0 for 3 cycles with a jump condition true -> `pc`, `taken`, and `jump_count` unchanged.
- Halt detection: jump to 0x0042, then at `pc`=0x0042 apply `target`=0x0042 with JMP -> `halted`=1 after the edge. It stays 1 over 10 further cycles while `jump_count` increments each cycle. Then `clr`=1 -> all outputs 0.
- Saturation (CNT_W=4): 17 consecutive taken jumps -> `jump_count` reaches 15 and holds; `taken`=1 throughout.
- Async reset mid-run: assert `rst_n`=0 between edges while `pc`=0x1234 and a jump is pending -> all outputs 0 before the next edge. After release, the first edge with `en`=1, `is_c`=0 gives `pc`=1.

Source files
------------

// File: rtl/hack_pc_if.sv
// Bus between the Hack CPU control/ALU side and the program counter.
interface hack_pc_if #(
   parameter int unsigned WIDTH = 15,
   parameter int unsigned CNT_W = 16
);
   logic             en;
   logic             clr;
   logic             is_c;
   logic [2:0]       jump;
   logic             zr;
   logic             ng;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] pc;
   logic             taken;
   logic             halted;
   logic [CNT_W-1:0] jump_count;

   // Control side drives the instruction/flag inputs and observes the PC state.
   modport master (
      output en, clr, is_c, jump, zr, ng, target,
      input  pc, taken, halted, jump_count
   );

   // Program counter side.
   modport slave (
      input  en, clr, is_c, jump, zr, ng, target,
      output pc, taken, halted, jump_count
   );
endinterface

// File: rtl/hack_pc.sv
// Hack-style program counter: increment or conditional jump on ALU flags,
// with taken-jump statistics and a sticky self-loop (halt) flag.
module hack_pc #(
   parameter int unsigned WIDTH = 15,
   parameter int unsigned CNT_W = 16
) (
   input logic       clk,
   input logic       rst_n,
   hack_pc_if.slave  bus
);

   localparam int unsigned PC_W  = WIDTH;
   localparam int unsigned CNT_WD = CNT_W;

   logic              cond;
   logic              count_full;
   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   pc_d;
   logic              taken_q;
   logic              taken_d;
   logic              halted_q;
   logic              halted_d;
   logic [CNT_WD-1:0] count_q;
   logic [CNT_WD-1:0] count_d;

   // Jump condition: lt/eq/gt bits against the ALU flags, C-instructions only.
   always_comb begin
      cond = bus.is_c & ((bus.jump[2] & bus.ng) |
                         (bus.jump[1] & bus.zr) |
                         (bus.jump[0] & ~bus.zr & ~bus.ng));
   end

   // Next-state selection: clear beats enable, stall holds everything.
   always_comb begin
      pc_d       = pc_q;
      taken_d    = taken_q;
      halted_d   = halted_q;
      count_d    = count_q;
      count_full = (count_q == {CNT_WD{1'b1}});
      if (bus.clr) begin
         pc_d     = '0;
         taken_d  = 1'b0;
         halted_d = 1'b0;
         count_d  = '0;
      end else if (bus.en) begin
         if (cond) begin
            pc_d    = bus.target;
            taken_d = 1'b1;
            if (!count_full) begin
               count_d = count_q + CNT_WD'(1);
            end
            if (bus.target == pc_q) begin
               halted_d = 1'b1;
            end
         end else begin
            pc_d    = pc_q + PC_W'(1);
            taken_d = 1'b0;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= '0;
         taken_q  <= 1'b0;
         halted_q <= 1'b0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         taken_q  <= taken_d;
         halted_q <= halted_d;
         count_q  <= count_d;
      end
   end

   assign bus.pc         = pc_q;
   assign bus.taken      = taken_q;
   assign bus.halted     = halted_q;
   assign bus.jump_count = count_q;

endmodule

// File: tb/tb_hack_pc.sv
// Directed bench for hack_pc (CNT_W=4 so counter saturation is reachable).
module tb_hack_pc;

   localparam int unsigned WIDTH = 15;
   localparam int unsigned CNT_W = 4;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   hack_pc_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   hack_pc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
   endtask

   task automatic load(input logic [WIDTH-1:0] addr);
      bus.en     = 1'b1;
      bus.is_c   = 1'b1;
      bus.jump   = 3'b111;
      bus.zr     = 1'b0;
      bus.ng     = 1'b0;
      bus.target = addr;
      tick();
      bus.is_c   = 1'b0;
      bus.jump   = 3'b000;
   endtask

   task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] tk,
                            input logic [31:0] hl, input logic [31:0] cnt);
      check({tag, ".pc"},     32'(bus.pc),         pc);
      check({tag, ".taken"},  32'(bus.taken),      tk);
      check({tag, ".halted"}, 32'(bus.halted),     hl);
      check({tag, ".count"},  32'(bus.jump_count), cnt);
   endtask

   // Jump-taken masks indexed by jump code; rows: positive, zero, negative.
   logic [7:0] take_mask [3];

   initial begin
      logic bit_t;
      passed = 0;
      total  = 0;
      take_mask[0] = 8'hAA;   // JGT, JGE, JNE, JMP
      take_mask[1] = 8'hCC;   // JEQ, JGE, JLE, JMP
      take_mask[2] = 8'hF0;   // JLT, JNE, JLE, JMP

      rst_n      = 1'b0;
      bus.en     = 1'b0;
      bus.clr    = 1'b0;
      bus.is_c   = 1'b0;
      bus.jump   = 3'b000;
      bus.zr     = 1'b0;
      bus.ng     = 1'b0;
      bus.target = '0;

      // Reset state, then increment 0..5.
      tick();
      tick();
      check_all("reset", 0, 0, 0, 0);
      bus.en = 1'b1;
      #2 rst_n = 1'b1;
      check("rel_hold.pc", 32'(bus.pc), 0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_all($sformatf("inc%0d", i), 32'(i), 0, 0, 0);
      end

      // Clear has priority over an enabled taken jump.
      bus.is_c = 1'b1; bus.jump = 3'b111; bus.target = 15'h05A5;
      do_clear();
      check_all("clr_prio", 0, 0, 0, 0);

      // Decode sweep: 8 codes x (pos, zero, neg) from pc=0x0010.
      for (int j = 0; j < 8; j++) begin
         for (int f = 0; f < 3; f++) begin
            do_clear();
            load(15'h0010);
            bus.is_c   = 1'b1;
            bus.jump   = 3'(j);
            bus.zr     = (f == 1);
            bus.ng     = (f == 2);
            bus.target = 15'h0100;
            tick();
            bit_t = take_mask[f][j];
            check($sformatf("dec j%0d f%0d pc", j, f), 32'(bus.pc), bit_t ? 32'h100 : 32'h11);
            check($sformatf("dec j%0d f%0d tk", j, f), 32'(bus.taken), 32'(bit_t));
            bus.zr = 1'b0; bus.ng = 1'b0;
         end
      end

      // A-instruction with all jump bits set increments.
      do_clear();
      load(15'h0010);
      bus.is_c = 1'b0; bus.jump = 3'b111; bus.target = 15'h0100;
      tick();
      check_all("a_instr", 32'h11, 0, 0, 1);

      // Wrap then stall with a true condition pending.
      do_clear();
      load(15'h7FFE);
      bus.is_c = 1'b0;
      tick();
      check("wrap1.pc", 32'(bus.pc), 32'h7FFF);
      tick();
      check_all("wrap2", 0, 0, 0, 1);
      bus.en = 1'b0; bus.is_c = 1'b1; bus.jump = 3'b111; bus.target = 15'h0055;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all($sformatf("stall%0d", i), 0, 0, 0, 1);
      end

      // Jump beats wrap at 0x7FFF.
      bus.en = 1'b1; bus.is_c = 1'b0;
      do_clear();
      load(15'h7FFF);
      load(15'h0003);
      check_all("wrap_jump", 3, 1, 0, 2);

      // Halt: self-jump at 0x0042 sets sticky flag and keeps counting.
      do_clear();
      load(15'h0042);
      check_all("pre_halt", 32'h42, 1, 0, 1);
      load(15'h0042);
      check_all("halt", 32'h42, 1, 1, 2);
      for (int i = 0; i < 10; i++) begin
         load(15'h0042);
         check_all($sformatf("halt_loop%0d", i), 32'h42, 1, 1, 32'(3 + i));
      end
      load(15'h0050);
      check_all("halt_sticky", 32'h50, 1, 1, 13);
      bus.en = 1'b0;
      do_clear();
      check_all("halt_clr", 0, 0, 0, 0);
      bus.en = 1'b1;

      // Saturation: 17 taken jumps to distinct targets.
      for (int i = 1; i <= 17; i++) begin
         load(15'(i * 2 + 1));
         check($sformatf("sat%0d.count", i), 32'(bus.jump_count), (i > 15) ? 32'd15 : 32'(i));
         check($sformatf("sat%0d.taken", i), 32'(bus.taken), 1);
      end

      // Async reset between edges with a jump pending.
      do_clear();
      load(15'h1234);
      bus.is_c = 1'b1; bus.jump = 3'b111; bus.target = 15'h0777;
      #2 rst_n = 1'b0;
      #1;
      check_all("async_rst", 0, 0, 0, 0);
      tick();
      check_all("rst_held", 0, 0, 0, 0);
      bus.is_c = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      check_all("post_rst", 1, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
